// File: rtl/counter_pkg.sv
// Shared types and helpers for the modulo counter slice.
// Direction enum, load clamp and prescaler width helper.
package counter_pkg;

  typedef enum logic {
    DIR_DOWN,
    DIR_UP
  } dir_e;

  function automatic int unsigned presc_width(
    input int unsigned prescale
  );
    return (prescale <= 1) ? 1 : $clog2(prescale);
  endfunction

  function automatic int unsigned clamp_load(
    input int unsigned value,
    input int unsigned modulus
  );
    return (value >= modulus) ? modulus - 1 : value;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: one-cycle enable tick every PRESCALE enabled clocks.
// Ports: clock, reset_n, enable, restart (clear|load), tick (comb).
module tick_gen
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  localparam int PW = presc_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_phase;

  assign tick = enable && (r_phase == LAST);

  // Phase freezes while enable is low so the tick
  // resumes exactly where it left off.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_phase <= '0;
    end else if (restart || tick) begin
      r_phase <= '0;
    end else if (enable) begin
      r_phase <= r_phase + 1'b1;
    end
  end

endmodule

// File: rtl/mod_counter.sv
// Synchronous modulo counter: up/down, wrap/saturate, load/clear.
// Ports: clock, reset_n, enable, up, saturate, clear, load,
// load_value -> count, tick (comb), terminal (registered pulse).
module mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             up,
  input  logic             saturate,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             terminal
);

  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_mod
    $error("mod_counter: MODULUS out of range");
  end
  if (PRESCALE < 1) begin : g_bad_pre
    $error("mod_counter: PRESCALE must be >= 1");
  end

  localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] TOP   = WIDTH'(MODULUS - 1);

  logic             w_restart;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH:0]   w_dec;
  logic             w_at_top;
  logic             w_at_bot;
  logic [WIDTH-1:0] w_load;
  dir_e             w_dir;

  logic [WIDTH-1:0] r_count;
  logic             r_terminal;

  assign w_restart = clear | load;
  assign w_dir     = dir_e'(up);

  // One extra bit: reaching MODULUS on increment or
  // borrowing below zero on decrement marks the bound.
  assign w_inc    = {1'b0, r_count} + 1'b1;
  assign w_dec    = {1'b0, r_count} - 1'b1;
  assign w_at_top = (w_inc == MOD_X);
  assign w_at_bot = w_dec[WIDTH];

  assign w_load = WIDTH'(clamp_load(32'(load_value),
                                    32'(MODULUS)));

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clock  (clock),
    .reset_n(reset_n),
    .enable (enable),
    .restart(w_restart),
    .tick   (tick)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count    <= '0;
      r_terminal <= 1'b0;
    end else begin
      priority case (1'b1)
        clear: begin
          r_count    <= '0;
          r_terminal <= 1'b0;
        end
        load: begin
          r_count    <= w_load;
          r_terminal <= 1'b0;
        end
        tick: begin
          unique case (w_dir)
            DIR_UP: begin
              r_terminal <= w_at_top;
              if (!w_at_top) begin
                r_count <= w_inc[WIDTH-1:0];
              end else if (!saturate) begin
                r_count <= '0;
              end
            end
            DIR_DOWN: begin
              r_terminal <= w_at_bot;
              if (!w_at_bot) begin
                r_count <= w_dec[WIDTH-1:0];
              end else if (!saturate) begin
                r_count <= TOP;
              end
            end
          endcase
        end
        default: begin
          r_terminal <= 1'b0;
        end
      endcase
    end
  end

  assign count    = r_count;
  assign terminal = r_terminal;

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter (MODULUS=10, PRESCALE=3 and 1).
// Table of vectors plus hand sequences for reset and runs.
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, up, sat, clr, ld;
  logic [3:0] ldv;

  logic [3:0] cnt_a, cnt_b;
  logic       tick_a, tick_b;
  logic       term_a, term_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mod_counter #(
    .WIDTH(4), .MODULUS(10), .PRESCALE(3)
  ) dut_a (
    .clock(clk), .reset_n(rst_n), .enable(en), .up(up),
    .saturate(sat), .clear(clr), .load(ld),
    .load_value(ldv), .count(cnt_a), .tick(tick_a),
    .terminal(term_a)
  );

  mod_counter #(
    .WIDTH(4), .MODULUS(10), .PRESCALE(1)
  ) dut_b (
    .clock(clk), .reset_n(rst_n), .enable(en), .up(up),
    .saturate(sat), .clear(clr), .load(ld),
    .load_value(ldv), .count(cnt_b), .tick(tick_b),
    .terminal(term_b)
  );

  typedef struct {
    logic       en, up, sat, clr, ld;
    logic [3:0] ldv;
    int         tick, cnt, term;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic e, input logic u,
                     input logic s, input logic c,
                     input logic l, input logic [3:0] v,
                     input int t, input int n, input int tm);
    vec_t r;
    r.en = e; r.up = u; r.sat = s; r.clr = c; r.ld = l;
    r.ldv = v; r.tick = t; r.cnt = n; r.term = tm;
    vq.push_back(r);
  endtask

  task automatic drive(input logic e, input logic u,
                       input logic s, input logic c,
                       input logic l, input logic [3:0] v);
    en = e; up = u; sat = s; clr = c; ld = l; ldv = v;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    int s;

    rst_n = 1'b0;
    drive(0, 1, 0, 0, 0, 4'd0);
    #2;
    chk("reset_cnt_a", cnt_a, 0);
    chk("reset_term_a", term_a, 0);
    chk("reset_cnt_b", cnt_b, 0);
    edge1();
    rst_n = 1'b1;

    // Free run, wrap at 10 steps.
    drive(1, 1, 0, 0, 0, 4'd0);
    pulses = 0;
    for (int i = 0; i < 36; i++) begin
      #1;
      chk($sformatf("run_tick_a%0d", i), tick_a,
          (i % 3 == 2) ? 1 : 0);
      chk($sformatf("run_tick_b%0d", i), tick_b, 1);
      edge1();
      s = (i + 1) / 3;
      chk($sformatf("run_cnt_a%0d", i), cnt_a, s % 10);
      chk($sformatf("run_term_a%0d", i), term_a,
          (i == 29) ? 1 : 0);
      chk($sformatf("run_cnt_b%0d", i), cnt_b, (i + 1) % 10);
      chk($sformatf("run_term_b%0d", i), term_b,
          ((i + 1) % 10 == 0) ? 1 : 0);
      if (term_a) pulses++;
    end
    chk("run_pulses_a", pulses, 1);

    // Vector table (DUT A), starts at count=2, phase=0.
    add(1, 1, 0, 0, 1, 4'd0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 4'd0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 4'd0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 4'd0, 1, 9, 1);
    add(0, 0, 0, 0, 0, 4'd0, 0, 9, 0);
    add(0, 1, 1, 0, 1, 4'd12, 0, 9, 0);
    for (int k = 0; k < 3; k++) begin
      add(1, 1, 1, 0, 0, 4'd0, 0, 9, 0);
      add(1, 1, 1, 0, 0, 4'd0, 0, 9, 0);
      add(1, 1, 1, 0, 0, 4'd0, 1, 9, 1);
    end
    add(1, 1, 0, 0, 0, 4'd0, 0, 9, 0);
    add(1, 1, 0, 0, 0, 4'd0, 0, 9, 0);
    add(1, 1, 0, 1, 1, 4'd5, 1, 0, 0);
    add(1, 1, 0, 0, 0, 4'd0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 4'd0, 0, 0, 0);
    add(1, 1, 0, 0, 1, 4'd5, 1, 5, 0);
    add(1, 1, 0, 0, 0, 4'd0, 0, 5, 0);
    add(1, 1, 0, 0, 0, 4'd0, 0, 5, 0);
    add(1, 1, 0, 0, 0, 4'd0, 1, 6, 0);
    add(1, 1, 0, 0, 0, 4'd0, 0, 6, 0);
    for (int k = 0; k < 7; k++)
      add(0, 1, 0, 0, 0, 4'd0, 0, 6, 0);
    add(1, 1, 0, 0, 0, 4'd0, 0, 6, 0);
    add(1, 1, 0, 0, 0, 4'd0, 1, 7, 0);
    add(1, 0, 1, 0, 1, 4'd0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 4'd0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 4'd0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 4'd0, 1, 0, 1);

    foreach (vq[i]) begin
      drive(vq[i].en, vq[i].up, vq[i].sat, vq[i].clr,
            vq[i].ld, vq[i].ldv);
      #1;
      chk($sformatf("vec%0d_tick", i), tick_a, vq[i].tick);
      edge1();
      chk($sformatf("vec%0d_cnt", i), cnt_a, vq[i].cnt);
      chk($sformatf("vec%0d_term", i), term_a, vq[i].term);
    end

    // Async reset mid-prescale at count 6.
    drive(1, 1, 0, 0, 1, 4'd6);
    edge1();
    chk("pre_rst_cnt", cnt_a, 6);
    drive(1, 1, 0, 0, 0, 4'd0);
    edge1();
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_cnt_a", cnt_a, 0);
    chk("async_rst_term_a", term_a, 0);
    chk("async_rst_cnt_b", cnt_b, 0);
    chk("rst_tick_a", tick_a, 0);
    chk("rst_tick_b", tick_b, 1);
    edge1();
    chk("rst_hold_cnt_a", cnt_a, 0);
    chk("rst_hold_cnt_b", cnt_b, 0);
    chk("rst_hold_tick_a", tick_a, 0);
    rst_n = 1'b1;

    // PRESCALE=1 run: a step every enabled cycle.
    for (int i = 0; i < 12; i++) begin
      edge1();
      chk($sformatf("p1_cnt%0d", i), cnt_b, (i + 1) % 10);
      chk($sformatf("p1_term%0d", i), term_b,
          (i == 9) ? 1 : 0);
    end

    // Saturated bound: B pulses every cycle, A once per 3.
    drive(1, 1, 1, 0, 1, 4'd12);
    edge1();
    chk("sat_load_b", cnt_b, 9);
    chk("sat_load_a", cnt_a, 9);
    drive(1, 1, 1, 0, 0, 4'd0);
    for (int k = 0; k < 3; k++) begin
      edge1();
      chk($sformatf("sat_cnt_b%0d", k), cnt_b, 9);
      chk($sformatf("sat_term_b%0d", k), term_b, 1);
      chk($sformatf("sat_term_a%0d", k), term_a,
          (k == 2) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
